// File: rtl/strhw_msg_driver_if.sv
// Streebog message-driver bundle: 64-bit word stream in, digest out, control-logic side.
// cl_state_i encoding: 0=CLEAR, 1=BUSY, 2=READY, 3=DONE.
interface strhw_msg_driver_if;
   logic [63:0]  msg_data_i;
   logic         msg_valid_i;
   logic         msg_ready_o;
   logic         msg_last_i;
   logic [3:0]   msg_bytes_i;
   logic         hash_size_i;
   logic [511:0] hash_o;
   logic         hash_valid_o;
   logic         hash_ready_i;
   logic         busy_o;
   logic         cl_trg_o;
   logic [1:0]   cl_state_i;
   logic [511:0] cl_block_o;
   logic [6:0]   cl_block_size_o;
   logic         cl_hash_size_o;
   logic [511:0] cl_hash_i;

   modport master (
      input  msg_data_i, msg_valid_i, msg_last_i, msg_bytes_i, hash_size_i,
             hash_ready_i, cl_state_i, cl_hash_i,
      output msg_ready_o, hash_o, hash_valid_o, busy_o, cl_trg_o,
             cl_block_o, cl_block_size_o, cl_hash_size_o
   );

   modport slave (
      output msg_data_i, msg_valid_i, msg_last_i, msg_bytes_i, hash_size_i,
             hash_ready_i, cl_state_i, cl_hash_i,
      input  msg_ready_o, hash_o, hash_valid_o, busy_o, cl_trg_o,
             cl_block_o, cl_block_size_o, cl_hash_size_o
   );
endinterface

// File: rtl/strhw_msg_driver.sv
// Packs 64-bit message words into 512-bit blocks and sequences the Streebog control logic.
// Words accepted only in IDLE/FILL; digest held on hash_o until hash_ready_i, blocking new messages.
module strhw_msg_driver #(
   parameter int GUARD_CYCLES = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   strhw_msg_driver_if.master  bus
);

   localparam logic [1:0] CL_CLEAR = 2'd0;
   localparam logic [1:0] CL_BUSY  = 2'd1;
   localparam logic [1:0] CL_READY = 2'd2;
   localparam logic [1:0] CL_DONE  = 2'd3;
   localparam int         GW       = $clog2(GUARD_CYCLES + 1);

   typedef enum logic [3:0] {
      S_GUARD, S_IDLE, S_FILL, S_START, S_WAIT_BUSY,
      S_WAIT_RESULT, S_PAD, S_HASH_OUT, S_RELEASE
   } fsm_t;

   fsm_t           state_q;
   logic [GW-1:0]  guard_cnt_q;
   logic [2:0]     k_q;
   logic [511:0]   block_q;
   logic [6:0]     size_q;
   logic           hash_sz_q;
   logic           last_seen_q;
   logic           msg_ready_q;
   logic           trg_q;
   logic           hash_valid_q;
   logic [511:0]   hash_q;
   logic           busy_q;

   logic [3:0]     n_eff;
   logic [63:0]    word_m;
   logic           accept;

   // Bytes past the final word's count are forced to zero; counts above 8 saturate.
   always_comb begin
      n_eff = 4'd8;
      if (bus.msg_last_i && (bus.msg_bytes_i < 4'd8))
         n_eff = bus.msg_bytes_i;
      word_m = '0;
      for (int j = 0; j < 8; j++)
         if (j < int'(n_eff))
            word_m[8*j +: 8] = bus.msg_data_i[8*j +: 8];
   end

   assign accept = bus.msg_valid_i & msg_ready_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_GUARD;
         guard_cnt_q  <= '0;
         k_q          <= '0;
         block_q      <= '0;
         size_q       <= '0;
         hash_sz_q    <= 1'b0;
         last_seen_q  <= 1'b0;
         msg_ready_q  <= 1'b0;
         trg_q        <= 1'b0;
         hash_valid_q <= 1'b0;
         hash_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         trg_q  <= 1'b0;
         busy_q <= 1'b1;
         case (state_q)
            S_GUARD: begin
               if (bus.cl_state_i == CL_CLEAR) begin
                  if (guard_cnt_q == GW'(GUARD_CYCLES - 1)) begin
                     guard_cnt_q <= '0;
                     msg_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= S_IDLE;
                  end else begin
                     guard_cnt_q <= guard_cnt_q + 1'b1;
                  end
               end else begin
                  guard_cnt_q <= '0;
               end
            end
            S_IDLE: begin
               if (accept) begin
                  hash_sz_q <= bus.hash_size_i;
                  block_q   <= {448'd0, word_m};
                  size_q    <= {3'd0, n_eff};
                  if (bus.msg_last_i) begin
                     last_seen_q <= 1'b1;
                     msg_ready_q <= 1'b0;
                     trg_q       <= 1'b1;
                     state_q     <= S_START;
                  end else begin
                     last_seen_q <= 1'b0;
                     k_q         <= 3'd1;
                     state_q     <= S_FILL;
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_FILL: begin
               if (accept) begin
                  block_q[{k_q, 6'd0} +: 64] <= word_m;
                  size_q <= size_q + {3'd0, n_eff};
                  if (bus.msg_last_i || (k_q == 3'd7)) begin
                     last_seen_q <= bus.msg_last_i;
                     msg_ready_q <= 1'b0;
                     trg_q       <= 1'b1;
                     state_q     <= S_START;
                  end else begin
                     k_q <= k_q + 3'd1;
                  end
               end
            end
            S_START: state_q <= S_WAIT_BUSY;
            S_WAIT_BUSY: begin
               if (bus.cl_state_i == CL_BUSY)
                  state_q <= S_WAIT_RESULT;
            end
            S_WAIT_RESULT: begin
               if (bus.cl_state_i == CL_READY) begin
                  if (last_seen_q) begin
                     state_q <= S_PAD;
                  end else begin
                     block_q     <= '0;
                     size_q      <= '0;
                     k_q         <= '0;
                     msg_ready_q <= 1'b1;
                     state_q     <= S_FILL;
                  end
               end else if (bus.cl_state_i == CL_DONE) begin
                  hash_q       <= hash_sz_q ? {256'd0, bus.cl_hash_i[255:0]} : bus.cl_hash_i;
                  hash_valid_q <= 1'b1;
                  state_q      <= S_HASH_OUT;
               end
            end
            // Message ended exactly on a block boundary: the control logic needs an empty block.
            S_PAD: begin
               block_q <= '0;
               size_q  <= '0;
               trg_q   <= 1'b1;
               state_q <= S_START;
            end
            S_HASH_OUT: begin
               if (bus.hash_ready_i) begin
                  hash_valid_q <= 1'b0;
                  trg_q        <= 1'b1;
                  state_q      <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               guard_cnt_q <= '0;
               state_q     <= S_GUARD;
            end
            default: state_q <= S_GUARD;
         endcase
      end
   end

   assign bus.msg_ready_o     = msg_ready_q;
   assign bus.hash_o          = hash_q;
   assign bus.hash_valid_o    = hash_valid_q;
   assign bus.busy_o          = busy_q;
   assign bus.cl_trg_o        = trg_q;
   assign bus.cl_block_o      = block_q;
   assign bus.cl_block_size_o = size_q;
   assign bus.cl_hash_size_o  = hash_sz_q;

endmodule

// File: tb/tb_strhw_msg_driver.sv
// Bench for strhw_msg_driver with a behavioural control-logic stub and directed messages.
module tb_strhw_msg_driver;

   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] READY = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   strhw_msg_driver_if bus();

   strhw_msg_driver #(.GUARD_CYCLES(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Control-logic stub: BUSY for 3 cycles, then READY on a 64-byte block, else DONE.
   int           ntrg, nrel, nbad, busy_left;
   logic [6:0]   last_sz;
   logic [511:0] blk_log [8];
   logic [6:0]   sz_log  [8];
   logic         hs_log  [8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.cl_state_i <= CLEAR;
         ntrg <= 0; nrel <= 0; nbad <= 0; busy_left <= 0; last_sz <= '0;
      end else if (bus.cl_trg_o && (bus.cl_state_i == CLEAR || bus.cl_state_i == READY)) begin
         blk_log[ntrg[2:0]] <= bus.cl_block_o;
         sz_log[ntrg[2:0]]  <= bus.cl_block_size_o;
         hs_log[ntrg[2:0]]  <= bus.cl_hash_size_o;
         last_sz   <= bus.cl_block_size_o;
         ntrg      <= ntrg + 1;
         busy_left <= 3;
         bus.cl_state_i <= BUSY;
      end else if (bus.cl_trg_o && bus.cl_state_i == DONE) begin
         nrel <= nrel + 1;
         bus.cl_state_i <= CLEAR;
      end else if (bus.cl_trg_o) begin
         nbad <= nbad + 1;
      end else if (bus.cl_state_i == BUSY) begin
         if (busy_left > 1) busy_left <= busy_left - 1;
         else bus.cl_state_i <= (last_sz == 7'd64) ? READY : DONE;
      end
   end

   task automatic wait_ready(input string tag);
      int t = 0;
      while (!bus.msg_ready_o && t < 200) begin @(negedge clk); t++; end
      check(tag, t < 200, 1'b1);
   endtask

   task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nb,
                             input logic hs);
      bus.msg_data_i  = d;
      bus.msg_last_i  = last;
      bus.msg_bytes_i = nb;
      bus.hash_size_i = hs;
      bus.msg_valid_i = 1'b1;
      wait_ready("word_accept");
      @(negedge clk);
      bus.msg_valid_i = 1'b0;
      bus.msg_last_i  = 1'b0;
   endtask

   task automatic send_msg(input int nbytes, input logic hs);
      int nw;
      nw = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
      for (int i = 0; i < nw; i++)
         drive_word(64'h0101_0101_0101_0101 * 64'(i + 1), i == nw - 1,
                    (i == nw - 1) ? 4'(nbytes - 8 * i) : 4'd8, hs);
   endtask

   task automatic wait_hash(input string tag);
      int t = 0;
      while (!bus.hash_valid_o && t < 300) begin @(negedge clk); t++; end
      check(tag, t < 300, 1'b1);
   endtask

   task automatic release_hash(input string tag);
      int r0;
      r0 = nrel;
      bus.hash_ready_i = 1'b1;
      @(negedge clk);
      bus.hash_ready_i = 1'b0;
      wait_ready({tag, "_idle"});
      check({tag, "_release_pulses"}, nrel - r0, 1);
   endtask

   int base, idx1, t, clears, stable, tb0;
   logic [511:0] h0;

   initial begin
      bus.msg_data_i = '0; bus.msg_valid_i = 1'b0; bus.msg_last_i = 1'b0;
      bus.msg_bytes_i = '0; bus.hash_size_i = 1'b0; bus.hash_ready_i = 1'b0;
      bus.cl_hash_i = {64{8'hA5}};
      repeat (2) @(negedge clk);

      check("rst_msg_ready", bus.msg_ready_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_trg", bus.cl_trg_o, 0);
      check("rst_hash_valid", bus.hash_valid_o, 0);
      check("rst_hash", bus.hash_o, 0);
      check("rst_block", bus.cl_block_o, 0);
      check("rst_size", bus.cl_block_size_o, 0);
      check("rst_hash_size", bus.cl_hash_size_o, 0);

      rst_n = 1'b1;
      t = 0;
      while (!bus.msg_ready_o && t < 50) begin @(negedge clk); t++; end
      check("guard_to_idle_cycles", t, 2);
      check("idle_busy", bus.busy_o, 0);

      // Empty message
      base = ntrg;
      drive_word(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 4'd0, 1'b0);
      check("empty_busy", bus.busy_o, 1);
      wait_hash("empty_hash_wait");
      check("empty_triggers", ntrg - base, 1);
      check("empty_block", blk_log[base % 8], 0);
      check("empty_size", sz_log[base % 8], 0);
      check("empty_hash", bus.hash_o, {64{8'hA5}});
      release_hash("empty");

      // "abc" with 256-bit digest
      base = ntrg;
      drive_word(64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3, 1'b1);
      wait_hash("abc_hash_wait");
      check("abc_triggers", ntrg - base, 1);
      check("abc_block", blk_log[base % 8], 512'h63_6261);
      check("abc_size", sz_log[base % 8], 3);
      check("abc_hash_size", hs_log[base % 8], 1);
      check("abc_hash256", bus.hash_o, {256'd0, {32{8'hA5}}});
      release_hash("abc");

      // Byte count above 8 saturates to a full word
      bus.cl_hash_i = {16{32'h0123_4567}};
      base = ntrg;
      drive_word(64'h8877_6655_4433_2211, 1'b1, 4'd12, 1'b0);
      wait_hash("over8_hash_wait");
      check("over8_block", blk_log[base % 8], 512'h8877_6655_4433_2211);
      check("over8_size", sz_log[base % 8], 8);
      check("over8_hash", bus.hash_o, {16{32'h0123_4567}});
      release_hash("over8");

      // 64-byte message: full block then empty pad block
      base = ntrg;
      idx1 = (base + 1) % 8;
      send_msg(64, 1'b0);
      wait_hash("m64_hash_wait");
      check("m64_triggers", ntrg - base, 2);
      check("m64_b0_w0", blk_log[base % 8][63:0], 64'h0101_0101_0101_0101);
      check("m64_b0_w7", blk_log[base % 8][511:448], 64'h0808_0808_0808_0808);
      check("m64_b0_size", sz_log[base % 8], 64);
      check("m64_pad_block", blk_log[idx1], 0);
      check("m64_pad_size", sz_log[idx1], 0);
      release_hash("m64");

      // 100-byte message: 64 + 36
      base = ntrg;
      idx1 = (base + 1) % 8;
      send_msg(100, 1'b0);
      wait_hash("m100_hash_wait");
      check("m100_triggers", ntrg - base, 2);
      check("m100_b0_size", sz_log[base % 8], 64);
      check("m100_b1_size", sz_log[idx1], 36);
      check("m100_b1_w0", blk_log[idx1][63:0], 64'h0909_0909_0909_0909);
      check("m100_b1_w4", blk_log[idx1][319:256], 64'h0000_0000_0D0D_0D0D);
      check("m100_b1_upper", blk_log[idx1][511:320], 0);
      release_hash("m100");

      // Digest backpressure
      send_msg(3, 1'b0);
      wait_hash("bp_hash_wait");
      h0 = bus.hash_o;
      tb0 = ntrg;
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.hash_valid_o || bus.hash_o !== h0 || bus.msg_ready_o || bus.cl_trg_o)
            stable = 0;
      end
      check("bp_stable", stable, 1);
      check("bp_no_trigger", ntrg - tb0, 0);
      bus.hash_ready_i = 1'b1;
      base = nrel;
      @(negedge clk);
      bus.hash_ready_i = 1'b0;
      check("bp_valid_dropped", bus.hash_valid_o, 0);
      t = 0; clears = 0;
      while (!bus.msg_ready_o && t < 50) begin
         @(negedge clk); t++;
         if (bus.cl_state_i == CLEAR && !bus.msg_ready_o) clears++;
      end
      check("bp_clear_cycles", clears, 2);
      check("bp_release_pulses", nrel - base, 1);

      // Reset while waiting for a result
      drive_word(64'h0000_0000_0063_6261, 1'b1, 4'd3, 1'b1);
      t = 0;
      while (bus.cl_state_i != BUSY && t < 50) begin @(negedge clk); t++; end
      check("rst_mid_reach_busy", t < 50, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", bus.busy_o, 0);
      check("rst_mid_trg", bus.cl_trg_o, 0);
      check("rst_mid_block", bus.cl_block_o, 0);
      check("rst_mid_size", bus.cl_block_size_o, 0);
      check("rst_mid_hash_size", bus.cl_hash_size_o, 0);
      check("rst_mid_hash", bus.hash_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      while (!bus.msg_ready_o && t < 50) begin @(negedge clk); t++; end
      check("rst_mid_guard_cycles", t, 2);
      check("rst_mid_no_hash", bus.hash_valid_o, 0);
      check("stray_triggers", nbad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/strhw_msg_driver.md
Name: strhw_msg_driver

Overview:
- Initiator-side front end for the Streebog control logic.
- Accepts a message as a stream of 64-bit words and packs the words into 512-bit blocks with byte counts.
- Drives the control logic's base interface (trigger/state) and data interface (block/size/hash_size), collects the final hash and presents it on a valid/ready output.
- Handles the terminating short block and the extra empty block, and returns the control logic to CLEAR between messages.

Parameters:
- GUARD_CYCLES, 2: idle cycles after control state reads CLEAR before the next trigger is allowed (minimum 2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- msg_data_i  in  64  message word; byte j = bits [8j+7:8j]
- msg_valid_i  in  1  word valid
- msg_ready_o  out  1  word accepted when valid&ready
- msg_last_i  in  1  final word of message
- msg_bytes_i  in  4  valid bytes in final word, 0..8; ignored (taken as 8) when last=0
- hash_size_i  in  1  0=512, 1=256; sampled with the first word of a message
- hash_o  out  512  digest; 256-bit result in bits [255:0], upper bits zero
- hash_valid_o  out  1  digest valid
- hash_ready_i  in  1  digest consumed
- busy_o  out  1  high whenever not in IDLE
- cl_trg_o  out  1  trigger to control logic
- cl_state_i  in  state_t  control state (CLEAR/BUSY/READY/DONE)
- cl_block_o  out  512  block to control logic
- cl_block_size_o  out  7  block byte count 0..64
- cl_hash_size_o  out  1  hash size to control logic
- cl_hash_i  in  512  control logic hash output

Behaviour:
- Reset (async assert, sync release): state GUARD with counter=0.
  - All outputs 0: msg_ready_o, hash_valid_o, cl_trg_o, busy_o, hash_o, cl_block_o, cl_block_size_o, cl_hash_size_o.
  - Control logic and driver share one reset event; mid-operation reset abandons the message with no hash output.
- FSM states: GUARD, IDLE, FILL, START, WAIT_BUSY, WAIT_RESULT, PAD, HASH_OUT, RELEASE.
- GUARD:
  - Counts consecutive cycles with cl_state_i==CLEAR.
  - After GUARD_CYCLES such cycles -> IDLE. Any non-CLEAR cycle resets the counter.
- IDLE: msg_ready_o=1. On the first accepted word, latch hash_size_i, store the word, then -> FILL (word counter k=1) or apply the final-word rules below.
- FILL: msg_ready_o=1.
  - Word k goes to block bits [64k+63:64k].
  - Final word: bytes beyond msg_bytes_i are forced to 0; all higher words are 0.
  - Size accumulator = 8*(full words) + msg_bytes_i of the final word.
  - Block completes on k==7 acceptance or on last. Then -> START with msg_ready_o=0.
- START:
  - cl_trg_o=1 for exactly one cycle; cl_block_o, cl_block_size_o and cl_hash_size_o are already valid.
  - These three outputs are held stable until WAIT_RESULT exits.
  - -> WAIT_BUSY.
- WAIT_BUSY: wait for cl_state_i==BUSY, then -> WAIT_RESULT.
- WAIT_RESULT:
  - On READY (block size 64, not final): clear the block buffer, k=0, -> FILL.
  - On READY when the message's last word is already consumed (final 64-byte block): -> PAD.
  - On DONE: capture cl_hash_i into hash_o in the same cycle, -> HASH_OUT.
- PAD: load block=0, size=0, -> START. The control logic ends on size<64.
- HASH_OUT:
  - hash_valid_o=1; hash_o is held stable until hash_ready_i.
  - On the handshake, drop valid and -> RELEASE.
  - No trigger or word acceptance while in HASH_OUT.
- RELEASE: one-cycle cl_trg_o pulse (control DONE->CLEAR), counter=0, -> GUARD.
- Empty message (last with bytes=0 on the first word): a single block of size 0.
- msg_bytes_i>8 with last is treated as 8.
- cl_block_size_o never exceeds 64.
- Unexpected cl_state_i values in wait states are ignored; the FSM keeps waiting. There is no timeout.

Test Plan:
- Empty message: one word, last=1, bytes=0, hash_size=0 -> one trigger with block=0 and size=0. Stub returns DONE with hash 0xA5.. -> hash_o=0xA5.., then RELEASE pulse.
- "abc" message: data=0xFFFF_FFFF_FF63_6261, last, bytes=3 -> cl_block_o=0x636261 with upper bits zero, size=3, single block.
- 64-byte message: 8 words, last on word 8 with bytes=8 -> block 1 size 64. Stub returns READY -> pad block size 0 -> DONE -> hash out. Exactly 2 triggers.
- 100-byte message: 13 words, last bytes=4 -> blocks of size 64 then 36. Word 8 maps to bits [63:0] of block 2.
- Backpressure: hold hash_ready_i=0 for 20 cycles -> hash_valid_o and hash_o stable, msg_ready_o=0, no cl_trg_o. Release -> one RELEASE pulse, then at least 2 CLEAR cycles before IDLE.
- Reset low during WAIT_RESULT -> all outputs 0 immediately. After release, the FSM reaches IDLE only after GUARD_CYCLES CLEAR cycles.
